// File: rtl/stream_mux_rr.sv
// Purpose: CH-channel, W-bit valid/ready stream mux with fixed-select or round-robin grant.
// Latency: 1 cycle from input accept to out_valid; sustains 1 word/cycle.
// Backpressure: out_ready=0 with a held word freezes the output stage and drops all in_ready.
// Optional MUX_STATS_EN: builds a 16-bit wrapping count of output transfers on xfer_cnt.
module stream_mux_rr #(
  parameter int CH    = 8,
  parameter int W     = 8,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   in_data,
  input  logic [CH-1:0]     in_valid,
  output logic [CH-1:0]     in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready,
  output logic [15:0]       xfer_cnt
);

  // Round-robin pointer: first channel examined on the next round-robin search.
  logic [SEL_W-1:0] rr_ptr;

  // Grant decision for the current cycle.
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [CH-1:0]    grant;
  logic [W-1:0]     grant_word;
  logic [SEL_W-1:0] rr_next;
  logic             load_en;

  // The output register may take a new word when it is empty or being drained now.
  assign load_en = !out_valid || out_ready;

  // Pick the granted channel: direct select in mode 0, rotating search from rr_ptr in mode 1.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      // An out-of-range sel simply matches no channel, so nothing is granted.
      for (int i = 0; i < CH; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk the search order backwards so the last hit is the first channel after rr_ptr.
      for (int k = CH - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr) + k) % CH;
        if (in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  // Expand the grant index to one-hot and select the granted channel's word.
  always_comb begin
    grant      = '0;
    grant_word = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_any && grant_idx == SEL_W'(i)) begin
        grant[i]   = 1'b1;
        grant_word = in_data[i*W +: W];
      end
    end
  end

  // Ready goes only to the granted channel, and only while the output stage can load.
  // Reset masks it so no producer sees a handshake that the reset will discard.
  assign in_ready = grant & {CH{load_en & ~rst}};

  // Pointer moves to the channel after the winner, wrapping at CH-1.
  assign rr_next = (grant_idx == SEL_W'(CH - 1)) ? '0 : grant_idx + SEL_W'(1);

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= grant_word;
        out_ch    <= grant_idx;
        if (mode) begin
          rr_ptr <= rr_next;
        end
      end else begin
        // Nothing to load: mark empty but leave the last data/channel visible.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_STATS_EN
  logic [15:0] xfer_cnt_q;

  // Count words taken by the consumer; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`else
  assign xfer_cnt = 16'd0;
`endif

endmodule
